// File: rtl/vga_timing_counter.sv
// vga_timing_counter: pixel-enable divider plus raster h/v counters with
// line/vblank/frame event pulses and a free-running frame counter.
module vga_timing_counter #(
    parameter int DIV     = 4,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int VD      = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [9:0]  h_count,
    output logic [9:0]  v_count,
    output logic        pixel_tick,
    output logic        line_end,
    output logic        vblank_start,
    output logic        frame_end,
    output logic [15:0] frame_count
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]    h_count_q, h_count_d;
    logic [9:0]    v_count_q, v_count_d;
    logic [15:0]   frame_count_q, frame_count_d;

    always_comb begin
        // Gating with rst_n keeps the DIV=1 tick quiet while reset is held.
        pixel_tick    = rst_n && en && (div_cnt_q == DW'(DIV - 1));
        line_end      = pixel_tick && (h_count_q == 10'(H_TOTAL - 1));
        vblank_start  = line_end && (v_count_q == 10'(VD - 1));
        frame_end     = line_end && (v_count_q == 10'(V_TOTAL - 1));
        div_cnt_d     = en ? ((div_cnt_q == DW'(DIV - 1)) ? '0 : div_cnt_q + DW'(1)) : div_cnt_q;
        h_count_d     = pixel_tick ? (line_end ? '0 : h_count_q + 10'd1) : h_count_q;
        v_count_d     = line_end ? (frame_end ? '0 : v_count_q + 10'd1) : v_count_q;
        frame_count_d = frame_end ? frame_count_q + 16'd1 : frame_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            h_count_q     <= '0;
            v_count_q     <= '0;
            frame_count_q <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign h_count     = h_count_q;
    assign v_count     = v_count_q;
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_timing_counter.sv
// tb_vga_timing_counter: directed vectors and corner sequences for the raster
// counter; a second tiny instance (1x1 raster, DIV=1) exercises frame_count wrap.
module tb_vga_timing_counter;
    localparam int DIV = 4, HT = 800, VT = 6, VDL = 4;

    logic        clk = 1'b0;
    logic        rst_n, en, rst2_n, en2;
    logic [9:0]  h, v, h2, v2;
    logic        tick, line, vbl, frm, tick2, line2, vbl2, frm2;
    logic [15:0] fc, fc2;
    int          checks = 0, errors = 0;

    vga_timing_counter #(.DIV(DIV), .H_TOTAL(HT), .V_TOTAL(VT), .VD(VDL)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .h_count(h), .v_count(v),
        .pixel_tick(tick), .line_end(line), .vblank_start(vbl),
        .frame_end(frm), .frame_count(fc)
    );

    vga_timing_counter #(.DIV(1), .H_TOTAL(1), .V_TOTAL(1), .VD(1)) dut2 (
        .clk(clk), .rst_n(rst2_n), .en(en2), .h_count(h2), .v_count(v2),
        .pixel_tick(tick2), .line_end(line2), .vblank_start(vbl2),
        .frame_end(frm2), .frame_count(fc2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic en;
        int   edges;
        int   h;
        int   v;
        logic tick;
        logic line;
        int   fc;
    } vec_t;

    vec_t vec [7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vec[0] = '{1'b1, 1, 0, 0, 1'b0, 1'b0, 0};
        vec[1] = '{1'b1, 1, 0, 0, 1'b0, 1'b0, 0};
        vec[2] = '{1'b1, 1, 0, 0, 1'b1, 1'b0, 0};
        vec[3] = '{1'b1, 1, 1, 0, 1'b0, 1'b0, 0};
        vec[4] = '{1'b1, 3, 1, 0, 1'b1, 1'b0, 0};
        vec[5] = '{1'b1, 1, 2, 0, 1'b0, 1'b0, 0};
        vec[6] = '{1'b1, 32, 10, 0, 1'b0, 1'b0, 0};
        rst_n = 1'b0; en = 1'b1; rst2_n = 1'b0; en2 = 1'b0;
        fork
            begin
                int n, cnt, vb, bad;
                repeat (5) @(negedge clk);
                chk("rst_h", h, 0); chk("rst_v", v, 0); chk("rst_fc", fc, 0);
                chk("rst_pulses", {tick, line, vbl, frm}, 0);
                rst_n = 1'b1;
                for (int i = 0; i < 7; i++) begin
                    en = vec[i].en;
                    step(vec[i].edges);
                    chk($sformatf("vec%0d_h", i), h, vec[i].h);
                    chk($sformatf("vec%0d_v", i), v, vec[i].v);
                    chk($sformatf("vec%0d_tick", i), tick, vec[i].tick);
                    chk($sformatf("vec%0d_line", i), line, vec[i].line);
                    chk($sformatf("vec%0d_fc", i), fc, vec[i].fc);
                end
                n = 0;
                while (!(h == 10'd799 && tick) && n < 4000) begin step(1); n++; end
                chk("line_wrap_edges", n, 3159);
                chk("line_wrap_pulses", {line, vbl, frm}, 3'b100);
                step(1);
                chk("line_wrap_h", h, 0); chk("line_wrap_v", v, 1); chk("line_wrap_le", line, 0);
                cnt = 0;
                for (int i = 0; i < 3200; i++) begin step(1); cnt += int'(line); end
                chk("line_end_per_3200", cnt, 1);
                chk("line2_h", h, 0); chk("line2_v", v, 2);
                n = 0; vb = 0;
                while (!frm && n < 30000) begin
                    step(1); n++;
                    if (vbl) begin
                        vb++;
                        chk("vblank_h", h, HT - 1); chk("vblank_v", v, VDL - 1);
                        step(1); n++;
                        chk("after_vblank_v", v, VDL); chk("after_vblank_h", h, 0);
                    end
                end
                chk("vblank_count", vb, 1);
                chk("frame_end_pos", {h, v}, {10'd799, 10'd5});
                chk("frame_end_line", line, 1);
                step(1);
                chk("frame_wrap_pos", {h, v}, 0); chk("frame_wrap_fc", fc, 1);
                chk("frame_wrap_pulses", {line, frm}, 0);
                n = 0;
                while (h != 10'd300 && n < 2000) begin step(1); n++; end
                step(1);
                en = 1'b0; bad = 0;
                for (int i = 0; i < 37; i++) begin
                    step(1);
                    if (h != 10'd300 || v != 10'd0 || tick || line || vbl || frm) bad++;
                end
                chk("freeze_bad_cycles", bad, 0);
                en = 1'b1;
                step(1); chk("resume_tick_early", tick, 0);
                step(1); chk("resume_tick", tick, 1); chk("resume_h_hold", h, 300);
                step(1); chk("resume_h", h, 301);
                n = 0;
                while (!(h == 10'd512 && v == 10'd3) && n < 20000) begin step(1); n++; end
                chk("pre_async_pos", {h, v}, {10'd512, 10'd3});
                #2 rst_n = 1'b0;
                #1;
                chk("async_pos", {h, v}, 0); chk("async_fc", fc, 0);
                chk("async_pulses", {tick, line, vbl, frm}, 0);
                @(negedge clk); rst_n = 1'b1;
                step(2);
                chk("post_async_fc", fc, 0); chk("post_async_pos", {h, v}, 0);
            end
            begin
                step(2);
                en2 = 1'b1;
                #1 chk("div1_tick_in_reset", tick2, 0);
                @(negedge clk); rst2_n = 1'b1;
                #1 chk("div1_pulses", {tick2, line2, vbl2, frm2}, 4'hF);
                step(65535);
                chk("fc_ffff", fc2, 16'hFFFF); chk("div1_pos", {h2, v2}, 0);
                step(1);
                chk("fc_wrap", fc2, 0);
                en2 = 1'b0;
                #1 chk("div1_tick_off", tick2, 0);
                step(2);
                chk("fc_hold", fc2, 0);
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_counter.md
Name: vga_timing_counter

Overview:
- Generates the pixel-rate raster position (h_count, v_count) consumed by the VGA sync/decode stage. That stage derives h_sync, v_sync and video_on combinationally from these counts.
- Divides the system clock down to a pixel-enable tick and advances the counters on each tick.
- Emits single-cycle line, vblank and frame event pulses for game-logic timing, plus a free-running frame counter.
- Sits directly upstream of the sync stage, between the top-level clock/reset and the rest of the display pipeline.

Parameters:
- DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16.
- H_TOTAL, 800, pixels per line (640 display + 16 FP + 96 retrace + 48 BP).
- V_TOTAL, 525, lines per frame (480 display + 10 FP + 2 retrace + 33 BP).
- VD, 480, visible lines; sets the vblank_start position.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  run enable; low freezes all state.
- h_count  output  10  horizontal position, 0..H_TOTAL-1, registered.
- v_count  output  10  vertical position, 0..V_TOTAL-1, registered.
- pixel_tick  output  1  high for one clk per pixel period.
- line_end  output  1  high on the tick where h_count = H_TOTAL-1.
- vblank_start  output  1  high on the last tick of line VD-1.
- frame_end  output  1  high on the last tick of the frame.
- frame_count  output  16  frames completed, wraps modulo 2^16.

Behaviour:
- Reset (rst_n low, any time, asynchronous):
  - div_cnt, h_count, v_count and frame_count go to 0.
  - All pulse outputs read 0 while rst_n is low.
  - The first pixel_tick after release occurs DIV clocks after the first clk edge with rst_n high and en high.
- Divider (internal div_cnt, 0..DIV-1):
  - When en = 1: if div_cnt = DIV-1 it wraps to 0, otherwise it increments.
  - When en = 0: div_cnt holds.
- pixel_tick = en && (div_cnt == DIV-1). It is combinational from registered state.
  - DIV = 1: pixel_tick equals en.
- Counter update, only on a clk edge where pixel_tick = 1:
  - If h_count = H_TOTAL-1: h_count <= 0, and v_count advances (wraps V_TOTAL-1 -> 0, otherwise increments).
  - Otherwise: h_count increments and v_count holds.
- Pulses are combinational and asserted in the same cycle as the qualifying pixel_tick, i.e. before the counters change:
  - line_end = pixel_tick && h_count == H_TOTAL-1.
  - vblank_start = line_end && v_count == VD-1.
  - frame_end = line_end && v_count == V_TOTAL-1.
- frame_count increments on the edge where frame_end = 1; 16'hFFFF wraps to 0.
- Each pulse is exactly one clk wide because pixel_tick is one clk wide.
  - line_end: once per H_TOTAL*DIV clocks.
  - vblank_start and frame_end: once per H_TOTAL*V_TOTAL*DIV clocks.
- en deasserted mid-line:
  - All counters and div_cnt freeze and all pulses are 0.
  - On re-enable, counting resumes from the frozen position with no skipped or doubled pixel.
- Simultaneous wrap: at (H_TOTAL-1, V_TOTAL-1), the single tick asserts line_end and frame_end together. The next state is (0, 0) and frame_count+1.
- Out-of-range counts cannot occur. Counters never reach H_TOTAL or V_TOTAL, so compare with equality only, never >=.
- Widths:
  - h_count and v_count are 10 bits, sufficient for H_TOTAL, V_TOTAL <= 1024.
  - div_cnt is sized by $clog2(DIV) with a minimum of 1 bit.
- Frame period (defaults): 800*525*4 = 1,680,000 clocks (about 59.5 Hz at 100 MHz).

Test Plan:
- Reset: hold rst_n low 5 clks with en=1, then release. Required: h_count=v_count=0, frame_count=0 and all pulses 0 during reset; first pixel_tick on the 4th clk after release; h_count=1 on the following edge.
- Tick spacing: run 40 clks. Required: pixel_tick high exactly every 4th clk; h_count advances 0->10 with no gaps.
- Line wrap: run to h_count=799, v_count=0. Required: line_end=1 on that tick, then h_count=0 and v_count=1; exactly one line_end per 3200 clks.
- Frame wrap: run to (799, 524). Required: line_end and frame_end both asserted for 1 clk, then (0,0) and frame_count=1. vblank_start fired once earlier at (799, 479), and v_count=480 on the following edge.
- Enable freeze: drop en at h_count=300 for 37 clks, then raise it. Required: counts and div phase unchanged during the freeze and all pulses 0; next tick occurs DIV minus the elapsed phase clocks after re-enable; h_count then reads 301.
- Async reset mid-frame: pulse rst_n low between clk edges at (512, 200). Required: outputs go to 0 immediately with no clk edge; frame_count=0 after release. Also preload near 16'hFFFF and pass one frame_end: frame_count must wrap to 0.
